// File: rtl/cpu_opponent_pkg.sv
// cpu_opponent_pkg
// Shared game constants for the automatic tennis opponent:
//   - oppState_t     : FSM state encoding (IDLE, REACT, SWING, MISS_WAIT)
//   - MISS_THRESH_*  : miss thresholds per difficulty level (64, 32, 8, 0)
//   - LFSR_SEED/TAPS : 16-bit Fibonacci LFSR seed and feedback tap mask
//   - missThreshold  : maps a 2-bit difficulty onto its miss threshold
package cpu_opponent_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REACT     = 2'd1,
    ST_SWING     = 2'd2,
    ST_MISS_WAIT = 2'd3
  } oppState_t;

  localparam logic [7:0] MISS_THRESH_D0 = 8'd64;
  localparam logic [7:0] MISS_THRESH_D1 = 8'd32;
  localparam logic [7:0] MISS_THRESH_D2 = 8'd8;
  localparam logic [7:0] MISS_THRESH_D3 = 8'd0;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Right-shifting Fibonacci register: polynomial taps 16,15,13,4 land on
  // state bits 0,1,3,12 and their XOR is shifted back in at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h100B;

  // A threshold of 0 means "sample < 0", which can never hold: no misses.
  function automatic logic [7:0] missThreshold(input logic [1:0] difficulty);
    logic [7:0] thresh;
    unique case (difficulty)
      2'd0:    thresh = MISS_THRESH_D0;
      2'd1:    thresh = MISS_THRESH_D1;
      2'd2:    thresh = MISS_THRESH_D2;
      default: thresh = MISS_THRESH_D3;
    endcase
    return thresh;
  endfunction

endpackage

// File: rtl/cpu_opponent_lfsr16.sv
// lfsr16
// 16-bit maximal-length Fibonacci LFSR, reusable wherever the game needs
// cheap pseudo-random bits (opponent misses, serve randomisation).
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-high reset, loads LFSR_SEED
//   stepEn_i : advance the register by one step this cycle
//   state_o  : current 16-bit register contents (never all-zero)
module lfsr16
  import cpu_opponent_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stepEn_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        feedback;

  // Next value: shift right and feed the tap parity into the top bit.
  // The all-zero lock-up state is unreachable from the seed, but should it
  // ever appear the register is pulled back onto the seed.
  always_comb begin
    feedback = ^(state_q & LFSR_TAPS);
    state_d  = state_q;
    if (stepEn_i) begin
      state_d = {feedback, state_q[15:1]};
      if (state_d == 16'h0000) begin
        state_d = LFSR_SEED;
      end
    end
  end

  // State register; reset restarts the sequence from the seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/cpu_opponent.sv
// cpu_opponent
// Automatic right-hand player for the tennis game. Watches the one-hot ball
// position, tracks ball direction, decides hit-or-miss from an LFSR when the
// ball arrives at TRIGGER_POS and, on a hit, raises `hit` after a reaction
// delay and holds it long enough for the slow game clock to see it.
// Ports:
//   clk        : system clock (only clock)
//   reset      : asynchronous active-high reset
//   enable     : opponent active; low forces IDLE and hit=0
//   difficulty : miss-rate select (0 = most misses, 3 = never misses)
//   lights     : ball position, one-hot; bit 15 player-0 end, bit 0 CPU end
//   hit        : registered swing output, drives hits[1] of the game block
//   busy       : high while reacting, swinging or waiting out a miss
module cpu_opponent
  import cpu_opponent_pkg::*;
#(
  parameter int unsigned REACT_CYCLES = 5_000_000,
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned TRIGGER_POS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  difficulty,
  input  logic [15:0] lights,
  output logic        hit,
  output logic        busy
);

  // A zero-length reaction or hold is meaningless; run it as one cycle.
  localparam int unsigned REACT_EFF = (REACT_CYCLES == 0) ? 1 : REACT_CYCLES;
  localparam int unsigned HOLD_EFF  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned MAX_CYC   = (REACT_EFF > HOLD_EFF) ? REACT_EFF : HOLD_EFF;
  localparam int unsigned CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] REACT_LOAD = CNT_W'(REACT_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       TRIG_IDX   = 4'(TRIGGER_POS);

  logic [15:0]      pos_q;
  logic [3:0]       idx;
  logic [4:0]       onesCount;
  logic             posValid;
  logic             posChanged;
  logic             approachNow;
  logic             returning;
  logic             trigger;
  logic             missNow;

  logic [3:0]       prevIdx_q;
  logic             approach_q;

  oppState_t        state_q;
  oppState_t        state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             hit_q;
  logic             hit_d;

  logic [15:0]      lfsrState;
  logic [7:0]       missSample;
  logic             unusedLfsrHi;

  lfsr16 u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .stepEn_i (1'b1),
    .state_o  (lfsrState)
  );

  assign missSample   = lfsrState[7:0];
  assign unusedLfsrHi = ^lfsrState[15:8];

  // Single input register for the ball position coming from the game block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= 16'h0000;
    end else begin
      pos_q <= lights;
    end
  end

  // One-hot check plus encoder: count set bits and remember the index of the
  // (only) set bit. Score flashes and the serve gap fail the one-hot test.
  always_comb begin
    idx       = 4'd0;
    onesCount = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (pos_q[i]) begin
        idx       = 4'(i);
        onesCount = onesCount + 5'd1;
      end
    end
  end

  // Events derived from the registered position. The direction used for the
  // trigger is the freshly computed one, so the decision happens in the same
  // cycle the new position is first seen.
  always_comb begin
    posValid    = (onesCount == 5'd1);
    posChanged  = posValid && (idx != prevIdx_q);
    approachNow = posChanged ? (idx < prevIdx_q) : approach_q;
    returning   = posChanged && (idx > prevIdx_q);
    trigger     = enable && posChanged && approachNow && (idx == TRIG_IDX);
    missNow     = (missSample < missThreshold(difficulty));
  end

  // Direction tracking only moves on a change of valid position, so invalid
  // patterns and a ball lingering in place leave it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prevIdx_q  <= 4'd15;
      approach_q <= 1'b0;
    end else if (posChanged) begin
      prevIdx_q  <= idx;
      approach_q <= (idx < prevIdx_q);
    end
  end

  // FSM state register, shared down-counter and the registered hit output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state logic. While reacting the ball position is ignored: a ball
  // that reaches index 0 still gets its (possibly late) swing, and the game
  // block judges it. Dropping enable aborts everything next cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!enable) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            if (missNow) begin
              state_d = ST_MISS_WAIT;
            end else begin
              state_d = ST_REACT;
              count_d = REACT_LOAD;
            end
          end
        end
        ST_REACT: begin
          if (count_q == '0) begin
            state_d = ST_SWING;
            count_d = HOLD_LOAD;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        ST_SWING: begin
          if (returning || !posValid || (count_q == '0)) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        ST_MISS_WAIT: begin
          if (!posValid || returning) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Outputs: hit is registered from the next state so it is glitch-free and
  // drops on reset without a clock; busy decodes the current state.
  always_comb begin
    hit_d = (state_d == ST_SWING);
    busy  = (state_q != ST_IDLE);
  end

  assign hit = hit_q;

endmodule

// File: tb/tb_cpu_opponent.sv
// tb_cpu_opponent
// Self-checking bench for cpu_opponent with REACT_CYCLES=4, HOLD_CYCLES=8.
// A behavioural model tracks the ball history and schedules the swing by
// absolute clock edge numbers; hit and busy are compared every cycle, with
// extra directed checks on the scenarios that matter most.
module tb_cpu_opponent;

  localparam int R  = 4;
  localparam int H  = 8;
  localparam int TP = 1;

  localparam int MODEL_IDLE     = 0;
  localparam int MODEL_PENDING  = 1;
  localparam int MODEL_SWINGING = 2;
  localparam int MODEL_MISSED   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [1:0]  difficulty = 2'd3;
  logic [15:0] lights = 16'h0000;
  logic        hit;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int hitHighCount = 0;

  int          edgeN;
  int          mMode;
  int          mSwingEdge;
  int          mPrev;
  logic [15:0] mPos;
  logic [15:0] mLfsr;
  logic        expHit;
  logic        expBusy;

  cpu_opponent #(
    .REACT_CYCLES (R),
    .HOLD_CYCLES  (H),
    .TRIGGER_POS  (TP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .difficulty (difficulty),
    .lights     (lights),
    .hit        (hit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Taps 16,15,13,4 of a right-shifting register are state bits 0,1,3,12.
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[1] ^ s[3] ^ s[12];
    return {fb, s[15:1]};
  endfunction

  function automatic int missLimit(input logic [1:0] d);
    case (d)
      2'd0:    return 64;
      2'd1:    return 32;
      2'd2:    return 8;
      default: return 0;
    endcase
  endfunction

  task automatic modelReset();
    edgeN      = 0;
    mMode      = MODEL_IDLE;
    mSwingEdge = 0;
    mPrev      = 15;
    mPos       = 16'h0000;
    mLfsr      = 16'hACE1;
    expHit     = 1'b0;
    expBusy    = 1'b0;
  endtask

  // One clock edge of the reference behaviour. mPos is the position the
  // opponent saw one edge ago; the swing is scheduled R edges after the
  // decision and lasts at most H edges.
  task automatic modelStep();
    int  ones;
    int  idx;
    bit  valid;
    bit  changed;
    edgeN++;
    ones = 0;
    idx  = 0;
    for (int i = 0; i < 16; i++) begin
      if (mPos[i]) begin
        ones++;
        idx = i;
      end
    end
    valid   = (ones == 1);
    changed = valid && (idx != mPrev);
    if (!enable) begin
      mMode = MODEL_IDLE;
    end else begin
      case (mMode)
        MODEL_IDLE: begin
          if (changed && idx < mPrev && idx == TP) begin
            if (int'(mLfsr[7:0]) < missLimit(difficulty)) begin
              mMode = MODEL_MISSED;
            end else begin
              mMode      = MODEL_PENDING;
              mSwingEdge = edgeN + R;
            end
          end
        end
        MODEL_PENDING: begin
          if (edgeN == mSwingEdge) mMode = MODEL_SWINGING;
        end
        MODEL_SWINGING: begin
          if (!valid || (changed && idx > mPrev) || edgeN == mSwingEdge + H) mMode = MODEL_IDLE;
        end
        default: begin
          if (!valid || (changed && idx > mPrev)) mMode = MODEL_IDLE;
        end
      endcase
    end
    if (changed) mPrev = idx;
    mPos    = lights;
    mLfsr   = lfsrNext(mLfsr);
    expHit  = (mMode == MODEL_SWINGING);
    expBusy = (mMode != MODEL_IDLE);
  endtask

  // Advance one clock, update the model, then compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("hit", {31'd0, hit}, {31'd0, expHit});
    checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
    if (hit === 1'b1) hitHighCount++;
  endtask

  task automatic applyStimulus(input logic [15:0] pattern, input int cycles);
    lights = pattern;
    repeat (cycles) tick();
  endtask

  task automatic applyReset();
    reset = 1'b1;
    #1;
    checkOutput("resetHit", {31'd0, hit}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    modelReset();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] peek;
    bit          found;
    bit          sawHit;
    int          pos;
    int          dir;
    int          r;

    // Reset with the ball sitting at the CPU end, then idle.
    modelReset();
    @(negedge clk);
    lights     = 16'h0001;
    enable     = 1'b1;
    difficulty = 2'd3;
    applyReset();
    hitHighCount = 0;
    applyStimulus(16'h0001, 20);
    checkOutput("idleNoHit", hitHighCount, 0);

    // Clean return: swing rises 6 clocks after the ball reaches index 1.
    applyStimulus(16'h0004, 3);
    lights = 16'h0002;
    repeat (5) tick();
    checkOutput("riseEarly", {31'd0, hit}, 32'd0);
    tick();
    checkOutput("riseAt6", {31'd0, hit}, 32'd1);
    lights = 16'h0004;
    tick();
    checkOutput("fallHeld", {31'd0, hit}, 32'd1);
    tick();
    checkOutput("fallAfterReturn", {31'd0, hit}, 32'd0);
    checkOutput("idleAfterReturn", {31'd0, busy}, 32'd0);

    // Hold timeout with the ball parked at the trigger position.
    applyStimulus(16'h0004, 3);
    lights = 16'h0002;
    hitHighCount = 0;
    repeat (30) tick();
    checkOutput("holdLen", hitHighCount, H);
    hitHighCount = 0;
    repeat (20) tick();
    checkOutput("noRetrigger", hitHighCount, 0);

    // Forced miss: wait for an LFSR sample below 64 at the decision edge.
    difficulty = 2'd0;
    applyStimulus(16'h0004, 3);
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      peek = lfsrNext(mLfsr);
      if (peek[7:0] < 8'd64) found = 1'b1;
      else tick();
    end
    checkOutput("missSearch", {31'd0, found}, 32'd1);
    lights = 16'h0002;
    tick();
    tick();
    checkOutput("missBusy", {31'd0, busy}, 32'd1);
    hitHighCount = 0;
    applyStimulus(16'h0001, 12);
    checkOutput("missNoHit", hitHighCount, 0);
    checkOutput("missStillBusy", {31'd0, busy}, 32'd1);
    lights = 16'h0000;
    tick();
    tick();
    checkOutput("missExit", {31'd0, busy}, 32'd0);

    // Ball moving away from the CPU never triggers.
    difficulty = 2'd3;
    hitHighCount = 0;
    applyStimulus(16'h0001, 3);
    applyStimulus(16'h0002, 3);
    applyStimulus(16'h0004, 3);
    checkOutput("awayNoHit", hitHighCount, 0);
    checkOutput("awayIdle", {31'd0, busy}, 32'd0);

    // Abort two cycles into REACT, then a normal retrigger.
    applyStimulus(16'h0008, 2);
    applyStimulus(16'h0004, 2);
    lights = 16'h0002;
    tick();
    tick();
    tick();
    tick();
    checkOutput("reactBusy", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    tick();
    checkOutput("abortHit", {31'd0, hit}, 32'd0);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    hitHighCount = 0;
    applyStimulus(16'h0002, 10);
    checkOutput("abortNoRetrig", hitHighCount, 0);
    applyStimulus(16'h0004, 2);
    lights = 16'h0002;
    sawHit = 1'b0;
    for (int t = 0; t < 12 && !sawHit; t++) begin
      tick();
      if (hit === 1'b1) sawHit = 1'b1;
    end
    checkOutput("reTrigger", {31'd0, sawHit}, 32'd1);

    // Asynchronous reset in the middle of a swing drops hit without a clock.
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncResetHit", {31'd0, hit}, 32'd0);
    checkOutput("asyncResetBusy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    modelReset();
    reset = 1'b0;

    // Randomised rallies: wandering ball, flashes, enable and difficulty churn.
    pos = 15;
    dir = -1;
    lights = 16'h8000;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        pos = pos + dir;
        if (pos < 0) begin
          pos = 1;
          dir = 1;
        end else if (pos > 15) begin
          pos = 14;
          dir = -1;
        end
        lights = 16'(1) << pos;
      end else if (r < 24) begin
        lights = r[0] ? 16'h0000 : (16'($urandom) | 16'h0101);
      end else if (r < 28) begin
        dir = -dir;
      end else if (r < 31) begin
        lights = 16'(1) << pos;
      end
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 99) < 3) difficulty = 2'($urandom_range(0, 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
